// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stepper_pkg
// Description : Shared types, mode encodings and the coil phase table for the
//               four-phase unipolar stepper sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package stepper_pkg;

  // Step mode encodings; 2'b11 is folded onto wave mode when latched.
  localparam logic [1:0] MODE_WAVE = 2'b00;
  localparam logic [1:0] MODE_FULL = 2'b01;
  localparam logic [1:0] MODE_HALF = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Eight-entry half-step table. Even entries energise one coil (wave),
  // odd entries energise two adjacent coils (full).
  function automatic logic [3:0] phase_of(input logic [2:0] idx);
    logic [3:0] p;
    case (idx)
      3'd0:    p = 4'b0001;
      3'd1:    p = 4'b0011;
      3'd2:    p = 4'b0010;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0100;
      3'd5:    p = 4'b1100;
      3'd6:    p = 4'b1000;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  // Map the raw MODE input onto one of the three supported modes.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    logic [1:0] r;
    case (m)
      MODE_FULL: r = MODE_FULL;
      MODE_HALF: r = MODE_HALF;
      default:   r = MODE_WAVE;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stepper_seq_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : step_timer
// Description : Reloadable down-counter pacing the stepper. A start pulse
//               latches the period and preloads the count; while running the
//               count decrements and reloads itself each time it hits zero.
// Revision    : 1.0 - initial release
// ============================================================================
module step_timer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] reload_q, reload_d;
  logic [DIV_W-1:0] start_val;

  // A period of zero behaves exactly like a period of one.
  assign start_val = (period == '0) ? '0 : period - DIV_W'(1);

  // Zero flag: the owner decides whether this cycle actually steps.
  assign tick = (count_q == '0);

  // Next count: preload on start, otherwise count down and wrap to reload.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    if (start) begin
      count_d  = start_val;
      reload_d = start_val;
    end else if (run) begin
      if (count_q == '0) begin
        count_d = reload_q;
      end else begin
        count_d = count_q - DIV_W'(1);
      end
    end
  end

  // Counter and reload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stepper_seq.sv
`default_nettype none
// ============================================================================
// Module      : stepper_seq
// Description : Four-phase unipolar stepper sequencer with wave/full/half
//               step modes, direction, programmable step period and step
//               count, and a start/stop/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module stepper_seq
  import stepper_pkg::*;
#(
  parameter int DIV_W   = 24,
  parameter int STEP_W  = 16,
  parameter bit HOLD_EN = 1'b1
) (
  input  logic              CLK100MHZ,
  input  logic              RST_N,
  input  logic              START,
  input  logic              STOP,
  input  logic              DIR,
  input  logic [1:0]        MODE,
  input  logic [DIV_W-1:0]  PERIOD,
  input  logic [STEP_W-1:0] STEPS,
  output logic [3:0]        PHASE,
  output logic              BUSY,
  output logic              DONE,
  output logic [STEP_W-1:0] STEPS_LEFT
);

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [3:0]        phase_q, phase_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [STEP_W-1:0] steps_left_q, steps_left_d;
  logic              dir_q, dir_d;
  logic [1:0]        mode_q, mode_d;

  logic              timer_start;
  logic              timer_run;
  logic              timer_tick;
  logic [1:0]        start_mode;
  logic [2:0]        start_idx;
  logic [2:0]        step_inc;
  logic [2:0]        idx_next;

  // Mode and aligned index used on the START edge; the alignment keeps idx
  // on even entries for wave/half and odd entries for full.
  assign start_mode = norm_mode(MODE);
  assign start_idx  = (start_mode == MODE_FULL) ? {idx_q[2:1], 1'b1}
                                                : {idx_q[2:1], 1'b0};

  // Next table position for a step; 3-bit arithmetic wraps mod 8.
  assign step_inc = (mode_q == MODE_HALF) ? 3'd1 : 3'd2;
  assign idx_next = dir_q ? (idx_q + step_inc) : (idx_q - step_inc);

  step_timer #(
    .DIV_W (DIV_W)
  ) u_step_timer (
    .clk    (CLK100MHZ),
    .rst_n  (RST_N),
    .start  (timer_start),
    .run    (timer_run),
    .period (PERIOD),
    .tick   (timer_tick)
  );

  // Next-state and output logic for the IDLE/RUN sequencer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    phase_d      = phase_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    steps_left_d = steps_left_q;
    dir_d        = dir_q;
    mode_d       = mode_q;
    timer_start  = 1'b0;
    timer_run    = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d      = RUN;
          dir_d        = DIR;
          mode_d       = start_mode;
          idx_d        = start_idx;
          phase_d      = phase_of(start_idx);
          steps_left_d = STEPS;
          busy_d       = 1'b1;
          timer_start  = 1'b1;
        end
      end

      RUN: begin
        if (STOP) begin
          // Abort takes priority over a step due on the same edge.
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (!HOLD_EN) begin
            phase_d = 4'b0000;
          end
        end else begin
          timer_run = 1'b1;
          if (timer_tick) begin
            idx_d   = idx_next;
            phase_d = phase_of(idx_next);
            // A zero count means continuous motion; it never decrements.
            if (steps_left_q != '0) begin
              steps_left_d = steps_left_q - STEP_W'(1);
              if (steps_left_q == STEP_W'(1)) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!HOLD_EN) begin
                  phase_d = 4'b0000;
                end
              end
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge CLK100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      phase_q      <= 4'b0000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      steps_left_q <= '0;
      dir_q        <= 1'b0;
      mode_q       <= MODE_WAVE;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      phase_q      <= phase_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      steps_left_q <= steps_left_d;
      dir_q        <= dir_d;
      mode_q       <= mode_d;
    end
  end

  assign PHASE      = phase_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign STEPS_LEFT = steps_left_q;

endmodule
`default_nettype wire

// File: doc/stepper_seq.md
Name: stepper_seq

Overview:
- Parametrised four-phase unipolar stepper sequencer.
- Drives the PMOD1_P7..P10 coil pins from CLK100MHZ.
- Successor to the fixed-sequence driver. Adds runtime-selectable wave/full/half-step mode, direction, programmable step period and step count, and a start/stop/busy/done handshake.
- Sits between the control logic (buttons/UART decode) and the PMOD output pins.

Parameters:
- DIV_W, 24, width of PERIOD (clock cycles per step).
- STEP_W, 16, width of STEPS and STEPS_LEFT.
- HOLD_EN, 1, 1 = keep the last coil pattern energised in IDLE; 0 = drive 0000 in IDLE.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  request a move; sampled only in IDLE.
- STOP  in  1  abort the move; sampled only in RUN.
- DIR  in  1  1 = forward (table index increments), 0 = reverse.
- MODE  in  2  00 wave, 01 full, 10 half, 11 treated as wave.
- PERIOD  in  DIV_W  cycles between steps; 0 treated as 1.
- STEPS  in  STEP_W  steps to take; 0 = continuous until STOP.
- PHASE  out  4  coil drive {P10,P9,P8,P7}.
- BUSY  out  1  high while in RUN.
- DONE  out  1  one-cycle pulse when a move ends (completed or stopped).
- STEPS_LEFT  out  STEP_W  remaining steps; stays 0 in continuous mode.

Behaviour:
- Reset (async, RST_N=0): PHASE=0000, BUSY=0, DONE=0, STEPS_LEFT=0, idx=0, state=IDLE, timer=0. All outputs are registered.
- Phase table, 8 entries indexed by idx 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
  - Wave mode uses even idx.
  - Full mode uses odd idx.
  - Half mode uses all eight entries.
- Step increment: +/-2 in wave/full, +/-1 in half. idx wraps mod 8 in both directions (7+1 -> 0, 0-1 -> 7, 0-2 -> 6).
- States: IDLE, RUN.
- IDLE -> RUN on the edge where START=1. At that edge:
  - Latch DIR, MODE, PERIOD, STEPS.
  - Align idx: wave/half clear bit0, full sets bit0.
  - PHASE <= table[aligned idx]. This first energise is not counted as a step.
  - timer <= max(PERIOD,1)-1, STEPS_LEFT <= STEPS, BUSY <= 1.
- In RUN, each edge:
  - If timer != 0: timer decrements.
  - If timer == 0: idx advances, PHASE <= table[new idx], timer reloads. If STEPS_LEFT != 0, it decrements.
  - If the step makes STEPS_LEFT go 1 -> 0: on the same edge state <= IDLE, BUSY <= 0, DONE <= 1.
- Latency: a move of N steps with period P started at edge k shows its last PHASE change, BUSY fall and DONE pulse at edge k+N*P.
- STOP in RUN: next edge goes to IDLE with BUSY=0, DONE=1 and no step. STOP beats a coincident timer==0 tick. STEPS_LEFT freezes at its current value.
- Ignored inputs:
  - START while BUSY.
  - STOP in IDLE.
  - Changes to DIR/MODE/PERIOD/STEPS during RUN (only the latched values are used).
- DONE is high for exactly one cycle and is cleared on the following edge.
- IDLE output:
  - HOLD_EN=1: PHASE holds its last value (0000 after reset until the first START).
  - HOLD_EN=0: PHASE <= 0000 on entering IDLE.
- idx persists across moves, so consecutive moves continue the sequence without a jump.
- Reset asserted mid-move: everything returns to reset values immediately. No DONE pulse.

Decomposition:
- Package stepper_pkg holds:
  - mode encodings MODE_WAVE/MODE_FULL/MODE_HALF;
  - state enum {IDLE, RUN};
  - the 8-entry phase table as a constant function phase_of(idx).
- One natural sub-module, step_timer: reloadable DIV_W down-counter with a tick output, asynchronous active-low reset.

Test Plan:
- Reset then half mode, DIR=1, PERIOD=3, STEPS=4, START pulse at edge 0 -> PHASE=0001 at edge 0; 0011/0010/0110/0100 at edges 3/6/9/12; BUSY falls and DONE=1 for one cycle at edge 12.
- Full mode, DIR=0, PERIOD=1, STEPS=5, starting from idx=4 -> aligned idx=5 (1100), then 0110, 0011, 1001, 1100, 0110 on consecutive edges; wrap 1 -> 7 is verified.
- Continuous wave mode (STEPS=0, PERIOD=2), STOP asserted on an edge where timer==0 -> no step taken that edge; BUSY=0 and DONE=1 next edge; STEPS_LEFT stays 0.
- PERIOD=0, STEPS=3 -> steps on every edge, identical to PERIOD=1.
- START held high throughout a move, and START pulsed mid-move -> no restart; exactly one DONE per move. HOLD_EN=0 build -> PHASE=0000 after DONE.
- RST_N dropped mid-move at an arbitrary (non-edge-aligned) time -> PHASE=0000, BUSY=0, STEPS_LEFT=0 immediately; no DONE pulse after reset is released.
